// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among byte-stream requesters.
// A grant is locked for a whole frame (or MAX_BURST bytes) and writes are spaced by MIN_GAP.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned MIN_GAP   = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_enable_i,
  input  logic                 tx_fifo_full_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           wdata_o,
  output logic                 wdata_qe_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic [15:0]          sent_count_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IdxW-1:0]    owner_q;
  logic [IdxW-1:0]    last_grant_q;
  logic [7:0]         burst_cnt_q;
  logic [7:0]         gap_cnt_q;
  logic [7:0]         wdata_q;
  logic               wdata_qe_q;
  logic               busy_q;
  logic [15:0]        sent_count_q;

  logic [IdxW-1:0]    pick_idx;
  logic               pick_found;
  logic [7:0]         owner_data;
  logic               owner_last;
  logic               accept_ok;
  logic               handshake;
  logic               release_grant;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    logic [IdxW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    owner_last = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IdxW'(k)) begin
        owner_data = req_data_i[8*k +: 8];
        owner_last = req_last_i[k];
      end
    end
  end

  // Gated by reset so no byte is taken from a requester in the reset cycle.
  assign accept_ok = ~rst_i & (state_q == StLock) & tx_enable_i & ~tx_fifo_full_i &
                     (gap_cnt_q == 8'd0);
  assign req_ready_o   = accept_ok ? grant_q : '0;
  assign handshake     = |(req_valid_i & req_ready_o);
  assign release_grant = handshake & (owner_last | (burst_cnt_q == 8'(MAX_BURST - 1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      wdata_q      <= '0;
      wdata_qe_q   <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      wdata_qe_q <= handshake;
      if (handshake) begin
        wdata_q      <= owner_data;
        sent_count_q <= sent_count_q + 16'd1;
        gap_cnt_q    <= 8'(MIN_GAP);
        burst_cnt_q  <= burst_cnt_q + 8'd1;
      end else if (gap_cnt_q != 8'd0) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q     <= StLock;
            owner_q     <= pick_idx;
            grant_q     <= NUM_REQ'(1) << pick_idx;
            busy_q      <= 1'b1;
            burst_cnt_q <= '0;
          end
        end
        StLock: begin
          if (release_grant) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= owner_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wdata_o      = wdata_q;
  assign wdata_qe_o   = wdata_qe_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign sent_count_o = sent_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a monitor logs every
// write strobe, and each scenario task checks the log against hand-computed sequences.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk_i;
  logic            rst_i;
  logic            tx_enable_i;
  logic            tx_fifo_full_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*8-1:0] req_data_i;
  logic [NR-1:0]   req_last_i;
  logic [NR-1:0]   req_ready_o;
  logic [7:0]      wdata_o;
  logic            wdata_qe_o;
  logic [NR-1:0]   grant_o;
  logic            busy_o;
  logic [15:0]     sent_count_o;

  int total;
  int bad;
  int cyc;

  logic [8:0] src_q [NR][$];
  logic [7:0] out_q [$];
  int         out_t [$];
  int         own_log [$];

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16), .MIN_GAP(20)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tx_enable_i    (tx_enable_i),
    .tx_fifo_full_i (tx_fifo_full_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .wdata_o        (wdata_o),
    .wdata_qe_o     (wdata_qe_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .sent_count_o   (sent_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Requester model: present queue head on the falling edge, pop when accepted.
  always @(negedge clk_i) begin
    for (int r = 0; r < NR; r++) begin
      if (src_q[r].size() > 0) begin
        req_valid_i[r]        = 1'b1;
        req_data_i[8*r +: 8]  = src_q[r][0][7:0];
        req_last_i[r]         = src_q[r][0][8];
      end else begin
        req_valid_i[r] = 1'b0;
        req_last_i[r]  = 1'b0;
      end
    end
    #1;
    for (int r = 0; r < NR; r++) begin
      if (req_valid_i[r] && req_ready_o[r]) begin
        void'(src_q[r].pop_front());
        own_log.push_back(r);
      end
    end
  end

  always @(negedge clk_i) begin
    if (wdata_qe_o === 1'b1) begin
      out_q.push_back(wdata_o);
      out_t.push_back(cyc);
    end
  end

  task automatic clear_logs();
    out_q.delete();
    out_t.delete();
    own_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i          = 1'b1;
    tx_enable_i    = 1'b1;
    tx_fifo_full_i = 1'b0;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_logs();
  endtask

  task automatic wait_out(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_i);
      #2;
      if (out_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_i);
      #2;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && busy_o === 1'b0 && wdata_qe_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++; if (wdata_o !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", wdata_o); end
    total++; if (wdata_qe_o !== 1'b0) begin bad++; $display("FAIL reset_qe got=%b exp=0", wdata_qe_o); end
    total++; if (grant_o !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (sent_count_o !== 16'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", sent_count_o); end
    total++; if (req_ready_o !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) src_q[0].push_back({i == 4, 8'(i)});
    wait_out(1, 100, ok);
    repeat (10) @(negedge clk_i);
    total++; if (wdata_o !== 8'h00 || wdata_qe_o !== 1'b0) begin
      bad++; $display("FAIL single_hold got=%h/%b exp=00/0", wdata_o, wdata_qe_o);
    end
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
    total++; if (out_q.size() !== 5) begin bad++; $display("FAIL single_count got=%0d exp=5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== 8'(i)) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, out_q[i], 8'(i)); end
    end
    for (int i = 1; i < 5 && i < out_t.size(); i++) begin
      total++; if (out_t[i] - out_t[i-1] !== 21) begin
        bad++; $display("FAIL single_gap%0d got=%0d exp=21", i, out_t[i] - out_t[i-1]);
      end
    end
    total++; if (sent_count_o !== 16'd5) begin bad++; $display("FAIL single_sent got=%0d exp=5", sent_count_o); end
    total++; if (grant_o !== 4'b0) begin bad++; $display("FAIL single_grant got=%b exp=0000", grant_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy_o); end
    total++; if (wdata_o !== 8'h04) begin bad++; $display("FAIL single_wdata_hold got=%h exp=04", wdata_o); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp [8];
    do_reset();
    for (int r = 0; r < NR; r++) begin
      src_q[r].push_back({1'b0, 8'(8'h10 * (r + 1))});
      src_q[r].push_back({1'b1, 8'(8'h10 * (r + 1) + 1)});
      exp[2*r]   = 8'(8'h10 * (r + 1));
      exp[2*r+1] = 8'(8'h10 * (r + 1) + 1);
    end
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=busy exp=idle"); end
    total++; if (out_q.size() !== 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp[i]) begin bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, out_q[i], exp[i]); end
    end
    total++; if (sent_count_o !== 16'd8) begin bad++; $display("FAIL rr_sent got=%0d exp=8", sent_count_o); end
  endtask

  task automatic test_burst();
    bit ok;
    int exp_own [$];
    logic [7:0] exp_dat [$];
    do_reset();
    for (int i = 0; i < 40; i++) src_q[1].push_back({1'b0, 8'(i)});
    src_q[2].push_back({1'b1, 8'hA0});
    src_q[2].push_back({1'b1, 8'hA1});
    for (int i = 0; i < 16; i++) begin exp_own.push_back(1); exp_dat.push_back(8'(i)); end
    exp_own.push_back(2); exp_dat.push_back(8'hA0);
    for (int i = 16; i < 32; i++) begin exp_own.push_back(1); exp_dat.push_back(8'(i)); end
    exp_own.push_back(2); exp_dat.push_back(8'hA1);
    for (int i = 32; i < 40; i++) begin exp_own.push_back(1); exp_dat.push_back(8'(i)); end
    wait_out(42, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_timeout got=%0d exp=42", out_q.size()); end
    repeat (50) @(negedge clk_i);
    total++; if (out_q.size() !== 42) begin bad++; $display("FAIL burst_count got=%0d exp=42", out_q.size()); end
    for (int i = 0; i < 42 && i < out_q.size() && i < own_log.size(); i++) begin
      total++; if (own_log[i] !== exp_own[i] || out_q[i] !== exp_dat[i]) begin
        bad++; $display("FAIL burst_item%0d got=r%0d/%h exp=r%0d/%h", i, own_log[i], out_q[i], exp_own[i], exp_dat[i]);
      end
    end
    total++; if (grant_o !== 4'b0010 || busy_o !== 1'b1) begin
      bad++; $display("FAIL burst_hold got=%b/%b exp=0010/1", grant_o, busy_o);
    end
    total++; if (sent_count_o !== 16'd42) begin bad++; $display("FAIL burst_sent got=%0d exp=42", sent_count_o); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int rdy_viol;
    int qe_viol;
    rdy_viol = 0;
    qe_viol  = 0;
    do_reset();
    for (int i = 0; i < 10; i++) src_q[0].push_back({i == 9, 8'(8'h50 + i)});
    wait_out(3, 200, ok);
    @(negedge clk_i);
    tx_fifo_full_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      #2;
      if (req_ready_o !== 4'b0) rdy_viol++;
      if (wdata_qe_o !== 1'b0) qe_viol++;
    end
    total++; if (rdy_viol !== 0) begin bad++; $display("FAIL full_ready got=%0d exp=0", rdy_viol); end
    total++; if (qe_viol !== 0) begin bad++; $display("FAIL full_qe got=%0d exp=0", qe_viol); end
    @(negedge clk_i);
    tx_fifo_full_i = 1'b0;
    wait_drain(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got=busy exp=idle"); end
    total++; if (out_q.size() !== 10) begin bad++; $display("FAIL full_count got=%0d exp=10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== 8'(8'h50 + i)) begin bad++; $display("FAIL full_byte%0d got=%h exp=%h", i, out_q[i], 8'(8'h50 + i)); end
    end
    total++; if (sent_count_o !== 16'd10) begin bad++; $display("FAIL full_sent got=%0d exp=10", sent_count_o); end
  endtask

  task automatic test_enable();
    bit ok;
    int viol;
    logic [7:0] exp [8];
    viol = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src_q[2].push_back({i == 5, 8'(8'h60 + i)});
      exp[i] = 8'(8'h60 + i);
    end
    src_q[3].push_back({1'b0, 8'h70});
    src_q[3].push_back({1'b1, 8'h71});
    exp[6] = 8'h70;
    exp[7] = 8'h71;
    wait_out(2, 200, ok);
    @(negedge clk_i);
    tx_enable_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      #2;
      if (grant_o !== 4'b0100 || wdata_qe_o !== 1'b0 || req_ready_o !== 4'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL enable_window got=%0d exp=0", viol); end
    @(negedge clk_i);
    tx_enable_i = 1'b1;
    wait_drain(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL enable_timeout got=busy exp=idle"); end
    total++; if (out_q.size() !== 8) begin bad++; $display("FAIL enable_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp[i]) begin bad++; $display("FAIL enable_byte%0d got=%h exp=%h", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) src_q[2].push_back({i == 5, 8'(8'h80 + i)});
    wait_out(3, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_start got=%0d exp=3", out_q.size()); end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    @(negedge clk_i);
    total++; if (wdata_o !== 8'h00 || wdata_qe_o !== 1'b0 || grant_o !== 4'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rmid_outputs got=%h/%b/%b/%b exp=00/0/0000/0", wdata_o, wdata_qe_o, grant_o, busy_o);
    end
    total++; if (sent_count_o !== 16'd0) begin bad++; $display("FAIL rmid_sent got=%0d exp=0", sent_count_o); end
    rst_i = 1'b0;
    clear_logs();
    @(negedge clk_i);
    total++; if (wdata_qe_o !== 1'b0) begin bad++; $display("FAIL rmid_post_qe got=%b exp=0", wdata_qe_o); end
    src_q[3].push_back({1'b1, 8'h93});
    src_q[0].push_back({1'b1, 8'h90});
    wait_drain(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=busy exp=idle"); end
    total++; if (own_log.size() !== 2 || (own_log.size() > 0 && own_log[0] !== 0)) begin
      bad++; $display("FAIL rmid_first_owner got=%0d entries exp=r0 first", own_log.size());
    end
    total++; if (out_q.size() !== 2 || (out_q.size() == 2 && (out_q[0] !== 8'h90 || out_q[1] !== 8'h93))) begin
      bad++; $display("FAIL rmid_bytes got=%0d bytes exp=90,93", out_q.size());
    end
    total++; if (sent_count_o !== 16'd2) begin bad++; $display("FAIL rmid_sent2 got=%0d exp=2", sent_count_o); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cyc            = 0;
    rst_i          = 1'b1;
    tx_enable_i    = 1'b1;
    tx_fifo_full_i = 1'b0;
    req_valid_i    = '0;
    req_data_i     = '0;
    req_last_i     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_fifo_full();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the UART TX FIFO write port (wdata/wdata qe) among NUM_REQ byte-stream requesters.
- Round-robin grant, locked per frame: a requester keeps the port until it signals last, or until MAX_BURST bytes have been written.
- Honours TX FIFO full and enforces a minimum gap between writes, so the FIFO is never over-driven.
- Sits between software/DMA byte sources and uart_core's TX write interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255)
MIN_GAP, 20, minimum idle cycles between two successive wdata writes (0..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
tx_enable_i  in  1  mirror of ctrl.tx; when low, no byte is accepted
tx_fifo_full_i  in  1  UART TX FIFO full status
req_valid_i  in  NUM_REQ  per-requester byte valid
req_data_i  in  NUM_REQ*8  per-requester byte; requester k at bits [8k+7:8k]
req_last_i  in  NUM_REQ  byte is last of its frame
req_ready_o  out  NUM_REQ  per-requester accept (combinational)
wdata_o  out  8  byte to the TX FIFO
wdata_qe_o  out  1  one-cycle write strobe
grant_o  out  NUM_REQ  one-hot current owner; zero when idle
busy_o  out  1  a grant is held
sent_count_o  out  16  total bytes written; wraps at 2^16

Behaviour:
- One clock domain. Reset is synchronous and active-high, on rst_i.
- Reset values: all outputs 0; state=IDLE; gap_cnt=0; burst_cnt=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-frame aborts the frame. No write strobe is issued in the reset cycle or the cycle after it.
- States:
  - IDLE: if any req_valid_i, select the first valid index scanning last_grant+1, last_grant+2, … modulo NUM_REQ. Register grant_o, set burst_cnt=0, go to LOCK. One-cycle arbitration latency; no byte is accepted in IDLE.
  - LOCK, owner g:
    - Accept condition: req_ready_o[g] = tx_enable_i & ~tx_fifo_full_i & (gap_cnt==0). All other ready bits are 0.
    - Handshake happens when req_valid_i[g] & req_ready_o[g].
    - On handshake:
      - Next cycle: wdata_o = accepted byte; wdata_qe_o=1 for exactly one cycle; sent_count_o += 1.
      - gap_cnt loads MIN_GAP and decrements to 0 once per cycle.
      - burst_cnt += 1.
    - Release on a handshake with req_last_i[g]=1, or when burst_cnt reaches MAX_BURST-1 before increment (the MAX_BURST-th byte). On release: last_grant=g; state=IDLE; grant_o=0 next cycle.
    - Owner drops req_valid_i mid-frame: grant is held indefinitely; there is no timeout.
  - gap_cnt continues counting in IDLE. A new owner still waits for gap_cnt==0.
- wdata_o holds its last value between strobes.
- tx_fifo_full_i is sampled combinationally into req_ready_o; a full in the same cycle blocks the handshake.
- tx_enable_i low: no handshakes; grant and state are retained; gap_cnt still decrements.
- Simultaneous valid on all requesters: strict rotation 0,1,2,3,0… per frame.
- MIN_GAP=0: back-to-back writes every cycle are allowed.

Test Plan:
- Single requester 0 sends 0x00..0x04, last on 0x04, MIN_GAP=20 -> 5 wdata_qe pulses 21 cycles apart, in order; sent_count_o=5; grant_o returns 0; busy_o=0.
- All 4 requesters each send a 2-byte frame simultaneously -> wdata order r0,r0,r1,r1,r2,r2,r3,r3; no interleaving within a frame.
- Requester 1 streams 40 bytes with no last, requester 2 also valid, MAX_BURST=16 -> grant alternates 1,2,1,… with 16 bytes per grant for requester 1.
- tx_fifo_full_i high for 100 cycles during a frame -> req_ready_o=0 and no wdata_qe for the whole window; stream resumes without loss or duplication.
- tx_enable_i deasserted mid-frame, then reasserted -> owner unchanged; byte sequence intact.
- rst_i pulsed mid-frame after 3 bytes -> all outputs 0; next grant goes to requester 0; sent_count_o restarts from 0.
